// File: rtl/hamming_read_ctrl_if.sv
// ---------------------------------------------------------------------------
// hamming_read_ctrl_if
// Bundles every signal of the Hamming read sequencer except clk/reset.
//
// Request handshake: a read is accepted on the rising clock edge where
// rd_req=1 and rd_ready=1; rd_addr is sampled on that same edge. The
// requester may hold or drop rd_req at any time; while rd_ready=0 the
// request is simply not seen.
//
// Modports:
//   master : the sequencer (drives strobes, selects, status, counter)
//   slave  : the surroundings (requester, drive, checker, fixer, decoder)
//
// Signal groups:
//   request  : rd_req, rd_addr, rd_ready
//   drive    : mem_rd_en, mem_addr
//   checker  : chk_valid, chk_synd_d0, chk_synd_d1
//   fixer    : fix_start, fix_sel, fix_done
//   decoder  : dec_en, dec_idx, dec_sel_fix
//   status   : rd_done, rd_err, err_code, corr_cnt, state_dbg
// ---------------------------------------------------------------------------
interface hamming_read_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              chk_valid;
  logic [3:0]        chk_synd_d0;
  logic [3:0]        chk_synd_d1;
  logic              fix_start;
  logic              fix_sel;
  logic              fix_done;
  logic              dec_en;
  logic              dec_idx;
  logic              dec_sel_fix;
  logic              rd_done;
  logic              rd_err;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  corr_cnt;
  logic [3:0]        state_dbg;

  modport master (
    input  rd_req, rd_addr, chk_valid, chk_synd_d0, chk_synd_d1, fix_done,
    output rd_ready, mem_rd_en, mem_addr, fix_start, fix_sel,
           dec_en, dec_idx, dec_sel_fix, rd_done, rd_err, err_code,
           corr_cnt, state_dbg
  );

  modport slave (
    output rd_req, rd_addr, chk_valid, chk_synd_d0, chk_synd_d1, fix_done,
    input  rd_ready, mem_rd_en, mem_addr, fix_start, fix_sel,
           dec_en, dec_idx, dec_sel_fix, rd_done, rd_err, err_code,
           corr_cnt, state_dbg
  );
endinterface

// File: rtl/hamming_read_ctrl.sv
// ---------------------------------------------------------------------------
// hamming_read_ctrl
// Read-path sequencer for the Hamming ECC RAID array. One read at a time:
// strobe the drive read for D0/D1, wait for both checker syndromes, push
// each correctable codeword through the fixer (D0 first), then feed the
// decoder one block per beat choosing raw or corrected data. Finishes with
// a one-cycle rd_done (rd_err/err_code qualify it) and keeps a saturating
// count of corrected codewords.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset (aborts a read, no rd_done)
//   bus    : hamming_read_ctrl_if.master (request, drive, checker, fixer,
//            decoder and status signals; state_dbg exposes the FSM state)
//
// Syndrome encoding: 0 clean, 1..12 bit position, 13..15 uncorrectable.
// err_code: 00 none, 01 uncorrectable, 10 timeout.
// All outputs are registered: they are loaded from the next-state value so
// they are a clean Moore function of the state held in the flops.
// ---------------------------------------------------------------------------
module hamming_read_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 reset,
  hamming_read_ctrl_if.master bus
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ISSUE     = 4'd1,
    S_WAIT_CHK  = 4'd2,
    S_FIX0_REQ  = 4'd3,
    S_FIX0_WAIT = 4'd4,
    S_FIX1_REQ  = 4'd5,
    S_FIX1_WAIT = 4'd6,
    S_DEC0      = 4'd7,
    S_DEC1      = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [TW-1:0]     timer;
  logic [3:0]        synd_d0;
  logic [3:0]        synd_d1;
  logic              fixed_0;
  logic              fixed_1;
  logic              fixed_0_n;
  logic              fixed_1_n;
  logic [1:0]        err_q;
  logic [1:0]        err_n;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic              timed_out;
  logic              fix_ack;

  // Timer reaches TIMEOUT on the last permitted wait cycle; an event that
  // arrives on that same cycle still takes priority over the abort.
  assign timed_out = (timer == TW'(TIMEOUT));
  assign fix_ack   = bus.fix_done &&
                     ((state == S_FIX0_WAIT) || (state == S_FIX1_WAIT));

  assign bus.mem_addr  = addr;
  assign bus.corr_cnt  = cnt;
  assign bus.state_dbg = state;

  // Next-state, next error code and next fixed flags.
  always_comb begin
    state_n   = state;
    err_n     = err_q;
    fixed_0_n = fixed_0 | (bus.fix_done && (state == S_FIX0_WAIT));
    fixed_1_n = fixed_1 | (bus.fix_done && (state == S_FIX1_WAIT));
    unique case (state)
      S_IDLE: begin
        if (bus.rd_req) state_n = S_ISSUE;
      end
      S_ISSUE: state_n = S_WAIT_CHK;
      S_WAIT_CHK: begin
        if (bus.chk_valid) begin
          if ((bus.chk_synd_d0 >= 4'd13) || (bus.chk_synd_d1 >= 4'd13)) begin
            state_n = S_DONE;
            err_n   = 2'b01;
          end else if (bus.chk_synd_d0 != 4'd0) begin
            state_n = S_FIX0_REQ;
          end else if (bus.chk_synd_d1 != 4'd0) begin
            state_n = S_FIX1_REQ;
          end else begin
            state_n = S_DEC0;
          end
        end else if (timed_out) begin
          state_n = S_DONE;
          err_n   = 2'b10;
        end
      end
      S_FIX0_REQ: state_n = S_FIX0_WAIT;
      S_FIX0_WAIT: begin
        if (bus.fix_done) begin
          state_n = (synd_d1 != 4'd0) ? S_FIX1_REQ : S_DEC0;
        end else if (timed_out) begin
          state_n = S_DONE;
          err_n   = 2'b10;
        end
      end
      S_FIX1_REQ: state_n = S_FIX1_WAIT;
      S_FIX1_WAIT: begin
        if (bus.fix_done) begin
          state_n = S_DEC0;
        end else if (timed_out) begin
          state_n = S_DONE;
          err_n   = 2'b10;
        end
      end
      S_DEC0: state_n = S_DEC1;
      S_DEC1: state_n = S_DONE;
      S_DONE: begin
        // Per-read context is wiped as we return to IDLE.
        state_n   = S_IDLE;
        err_n     = 2'b00;
        fixed_0_n = 1'b0;
        fixed_1_n = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      timer           <= '0;
      synd_d0         <= '0;
      synd_d1         <= '0;
      fixed_0         <= 1'b0;
      fixed_1         <= 1'b0;
      err_q           <= 2'b00;
      addr            <= '0;
      cnt             <= '0;
      bus.rd_ready    <= 1'b1;
      bus.mem_rd_en   <= 1'b0;
      bus.fix_start   <= 1'b0;
      bus.fix_sel     <= 1'b0;
      bus.dec_en      <= 1'b0;
      bus.dec_idx     <= 1'b0;
      bus.dec_sel_fix <= 1'b0;
      bus.rd_done     <= 1'b0;
      bus.rd_err      <= 1'b0;
      bus.err_code    <= 2'b00;
    end else begin
      state   <= state_n;
      err_q   <= err_n;
      fixed_0 <= fixed_0_n;
      fixed_1 <= fixed_1_n;

      unique case (state)
        S_IDLE, S_ISSUE, S_FIX0_REQ, S_FIX1_REQ: timer <= '0;
        S_WAIT_CHK, S_FIX0_WAIT, S_FIX1_WAIT:   timer <= timer + TW'(1);
        default:                                timer <= timer;
      endcase

      if ((state == S_IDLE) && bus.rd_req) addr <= bus.rd_addr;

      if ((state == S_WAIT_CHK) && bus.chk_valid) begin
        synd_d0 <= bus.chk_synd_d0;
        synd_d1 <= bus.chk_synd_d1;
      end

      if (state == S_DONE) begin
        synd_d0 <= '0;
        synd_d1 <= '0;
        addr    <= '0;
      end

      // Saturating: stays at all-ones once reached.
      if (fix_ack && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);

      bus.rd_ready    <= (state_n == S_IDLE);
      bus.mem_rd_en   <= (state_n == S_ISSUE);
      bus.fix_start   <= (state_n == S_FIX0_REQ) || (state_n == S_FIX1_REQ);
      bus.fix_sel     <= (state_n == S_FIX1_REQ) || (state_n == S_FIX1_WAIT);
      bus.dec_en      <= (state_n == S_DEC0) || (state_n == S_DEC1);
      bus.dec_idx     <= (state_n == S_DEC1);
      bus.dec_sel_fix <= ((state_n == S_DEC0) && fixed_0_n) ||
                         ((state_n == S_DEC1) && fixed_1_n);
      bus.rd_done     <= (state_n == S_DONE);
      bus.rd_err      <= (state_n == S_DONE) && (err_n != 2'b00);
      bus.err_code    <= (state_n == S_DONE) ? err_n : 2'b00;
    end
  end

endmodule

// File: tb/tb_hamming_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hamming_read_ctrl
// Directed bench for hamming_read_ctrl. Each read is described by its
// syndromes and checker/fixer latencies; a transaction-level model expands
// that description into the per-cycle inputs to drive and the per-cycle
// outputs the sequencer must show. One compare process checks every cycle
// of every planned read, a monitor collects per-read event timing that is
// then pinned against hand-computed constants, and a manual reset sequence
// checks the abort behaviour.
// ---------------------------------------------------------------------------
module tb_hamming_read_ctrl;

  typedef struct packed {
    logic       rd_ready;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic       fix_start;
    logic       fix_sel;
    logic       dec_en;
    logic       dec_idx;
    logic       dec_sel_fix;
    logic       rd_done;
    logic       rd_err;
    logic [1:0] err_code;
    logic [15:0] corr_cnt;
  } out_t;

  typedef struct packed {
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       chk_valid;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       fix_done;
  } in_t;

  localparam int OW = $bits(out_t);
  localparam int IW = $bits(in_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hamming_read_ctrl_if #(.ADDR_W(8), .CNT_W(16)) bus ();

  hamming_read_ctrl #(.ADDR_W(8), .TIMEOUT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q[$];
  logic [IW-1:0] drv_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;
  int txn      = 0;

  int acc_cyc[8];
  int done_cyc[8];
  int done_err[8];
  int done_code[8];
  int done_corr[8];
  int mem_n[8];
  int fix_n[8];
  int fix_sel0[8];
  int fix_last_sel[8];
  int dec_n[8];
  int dec0_sel[8];
  int dec1_sel[8];

  // ---------------- model ----------------
  function automatic out_t base_out(input logic [7:0] a);
    out_t o;
    o = '0;
    o.mem_addr = a;
    o.corr_cnt = m_cnt[15:0];
    return o;
  endfunction

  // Inputs while nothing is being offered: junk on the syndrome lines so a
  // design that latches them without chk_valid goes wrong.
  function automatic in_t idle_in();
    in_t i;
    i = '0;
    i.rd_addr = 8'hA5;
    i.s0 = 4'hE;
    i.s1 = 4'hD;
    return i;
  endfunction

  function automatic void step(input in_t i, input out_t o);
    drv_q.push_back(i);
    exp_q.push_back(o);
  endfunction

  function automatic void finish_txn(input logic [7:0] a, input logic [1:0] code);
    out_t o;
    o = base_out(a);
    o.rd_done  = 1'b1;
    o.rd_err   = (code != 2'b00);
    o.err_code = code;
    step(idle_in(), o);
  endfunction

  // One fixer round trip: a start cycle, then up to 16 wait cycles. lat is
  // the wait cycle carrying fix_done (1..16), 0 means the fixer never answers.
  function automatic bit plan_fix(input logic [7:0] a, input bit n, input int lat);
    out_t o;
    in_t  i;
    int   len;
    o = base_out(a);
    o.fix_start = 1'b1;
    o.fix_sel   = n;
    step(idle_in(), o);
    len = (lat == 0) ? 16 : lat;
    for (int w = 1; w <= len; w++) begin
      o = base_out(a);
      o.fix_sel = n;
      i = idle_in();
      if (w == lat) i.fix_done = 1'b1;
      step(i, o);
    end
    if (lat == 0) begin
      finish_txn(a, 2'b10);
      return 1'b0;
    end
    if (m_cnt < 65535) m_cnt++;
    return 1'b1;
  endfunction

  // chk_wait: WAIT_CHK cycle (1..16) carrying chk_valid; 0 = never.
  // busy_req: pulse a second request during the second wait cycle.
  function automatic void plan_read(input logic [7:0] a, input int chk_wait,
                                    input logic [3:0] s0, input logic [3:0] s1,
                                    input int lat0, input int lat1,
                                    input bit busy_req);
    out_t o;
    in_t  i;
    int   len;
    bit   f0;
    bit   f1;
    o = '0;
    o.rd_ready = 1'b1;
    o.corr_cnt = m_cnt[15:0];
    i = idle_in();
    i.rd_req  = 1'b1;
    i.rd_addr = a;
    step(i, o);
    // Drive read cycle, with a stray checker result that must be ignored.
    o = base_out(a);
    o.mem_rd_en = 1'b1;
    i = idle_in();
    i.chk_valid = 1'b1;
    i.s0 = 4'hF;
    i.s1 = 4'hF;
    step(i, o);
    len = (chk_wait == 0) ? 16 : chk_wait;
    for (int w = 1; w <= len; w++) begin
      o = base_out(a);
      i = idle_in();
      if (w == chk_wait) begin
        i.chk_valid = 1'b1;
        i.s0 = s0;
        i.s1 = s1;
      end
      if (busy_req && w == 2) begin
        i.rd_req  = 1'b1;
        i.rd_addr = ~a;
      end
      step(i, o);
    end
    if (chk_wait == 0) begin
      finish_txn(a, 2'b10);
      return;
    end
    if (s0 >= 4'd13 || s1 >= 4'd13) begin
      finish_txn(a, 2'b01);
      return;
    end
    f0 = 1'b0;
    f1 = 1'b0;
    if (s0 != 4'd0) begin
      if (!plan_fix(a, 1'b0, lat0)) return;
      f0 = 1'b1;
    end
    if (s1 != 4'd0) begin
      if (!plan_fix(a, 1'b1, lat1)) return;
      f1 = 1'b1;
    end
    o = base_out(a);
    o.dec_en = 1'b1;
    o.dec_idx = 1'b0;
    o.dec_sel_fix = f0;
    step(idle_in(), o);
    o = base_out(a);
    o.dec_en = 1'b1;
    o.dec_idx = 1'b1;
    o.dec_sel_fix = f1;
    step(idle_in(), o);
    finish_txn(a, 2'b00);
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input in_t i);
    bus.rd_req      = i.rd_req;
    bus.rd_addr     = i.rd_addr;
    bus.chk_valid   = i.chk_valid;
    bus.chk_synd_d0 = i.s0;
    bus.chk_synd_d1 = i.s1;
    bus.fix_done    = i.fix_done;
  endtask

  task automatic drive_all();
    in_t d;
    while (drv_q.size() != 0) begin
      @(negedge clk);
      d = drv_q.pop_front();
      if (bus.rd_ready && d.rd_req) begin
        acc_cyc[txn] = cyc;
        txn++;
      end
      apply(d);
    end
    @(negedge clk);
    apply(idle_in());
  endtask

  function automatic out_t sample_out();
    out_t g;
    g.rd_ready    = bus.rd_ready;
    g.mem_rd_en   = bus.mem_rd_en;
    g.mem_addr    = bus.mem_addr;
    g.fix_start   = bus.fix_start;
    g.fix_sel     = bus.fix_sel;
    g.dec_en      = bus.dec_en;
    g.dec_idx     = bus.dec_idx;
    g.dec_sel_fix = bus.dec_sel_fix;
    g.rd_done     = bus.rd_done;
    g.rd_err      = bus.rd_err;
    g.err_code    = bus.err_code;
    g.corr_cnt    = bus.corr_cnt;
    return g;
  endfunction

  // ---------------- compare process ----------------
  out_t cmp_e;
  out_t cmp_g;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      cmp_g = sample_out();
      // The address is only defined from accept until the return to IDLE.
      if (cmp_e.rd_ready) begin
        cmp_e.mem_addr = 8'h00;
        cmp_g.mem_addr = 8'h00;
      end
      n_checks++;
      if (cmp_g !== cmp_e) begin
        n_fail++;
        $display("FAIL cycle_check cyc=%0d got=%h exp=%h", cyc, cmp_g, cmp_e);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (txn > 0 && txn <= 8) begin
      if (bus.mem_rd_en) mem_n[txn-1]++;
      if (bus.fix_start) begin
        if (fix_n[txn-1] == 0) fix_sel0[txn-1] = int'(bus.fix_sel);
        fix_last_sel[txn-1] = int'(bus.fix_sel);
        fix_n[txn-1]++;
      end
      if (bus.dec_en) begin
        dec_n[txn-1]++;
        if (!bus.dec_idx) dec0_sel[txn-1] = int'(bus.dec_sel_fix);
        else              dec1_sel[txn-1] = int'(bus.dec_sel_fix);
      end
      if (bus.rd_done) begin
        done_cyc[txn-1]  = cyc;
        done_err[txn-1]  = int'(bus.rd_err);
        done_code[txn-1] = int'(bus.err_code);
        done_corr[txn-1] = int'(bus.corr_cnt);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- main sequence ----------------
  in_t mi;
  initial begin
    foreach (acc_cyc[k]) begin
      acc_cyc[k] = 0; done_cyc[k] = -1000; done_err[k] = -1; done_code[k] = -1;
      done_corr[k] = -1; mem_n[k] = 0; fix_n[k] = 0; fix_sel0[k] = -1;
      fix_last_sel[k] = -1; dec_n[k] = 0; dec0_sel[k] = -1; dec1_sel[k] = -1;
    end
    apply(idle_in());
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_ready", int'(bus.rd_ready), 1);
    chk("reset_mem_rd_en", int'(bus.mem_rd_en), 0);
    chk("reset_rd_done", int'(bus.rd_done), 0);
    chk("reset_corr_cnt", int'(bus.corr_cnt), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    plan_read(8'h3C, 3, 4'd0,  4'd0, 0, 0,  1'b0);  // clean
    plan_read(8'h5A, 2, 4'd0,  4'd5, 0, 3,  1'b0);  // D1 only
    plan_read(8'hC3, 1, 4'd3,  4'd9, 2, 4,  1'b0);  // both blocks
    plan_read(8'h81, 2, 4'd14, 4'd0, 0, 0,  1'b0);  // uncorrectable
    plan_read(8'h42, 0, 4'd0,  4'd0, 0, 0,  1'b1);  // checker timeout, busy req
    plan_read(8'h17, 1, 4'd0,  4'd7, 0, 16, 1'b0);  // fix_done on timeout cycle
    plan_read(8'hE8, 1, 4'd2,  4'd0, 0, 0,  1'b0);  // fixer timeout
    drive_all();

    chk("txn_count", txn, 7);
    chk("clean_mem_lat", done_cyc[0] - acc_cyc[0] - 6, 1);
    chk("clean_done_lat", done_cyc[0] - acc_cyc[0], 7);
    chk("clean_dec_sel", dec0_sel[0] + dec1_sel[0], 0);
    chk("clean_corr", done_corr[0], 0);
    chk("d1_fix_n", fix_n[1], 1);
    chk("d1_fix_sel", fix_last_sel[1], 1);
    chk("d1_dec0_sel", dec0_sel[1], 0);
    chk("d1_dec1_sel", dec1_sel[1], 1);
    chk("d1_corr", done_corr[1], 1);
    chk("d1_done_lat", done_cyc[1] - acc_cyc[1], 10);
    chk("both_fix_n", fix_n[2], 2);
    chk("both_first_sel", fix_sel0[2], 0);
    chk("both_second_sel", fix_last_sel[2], 1);
    chk("both_dec_sel", dec0_sel[2] + dec1_sel[2], 2);
    chk("both_corr", done_corr[2], 3);
    chk("both_done_lat", done_cyc[2] - acc_cyc[2], 13);
    chk("unc_fix_n", fix_n[3], 0);
    chk("unc_dec_n", dec_n[3], 0);
    chk("unc_err", done_err[3], 1);
    chk("unc_code", done_code[3], 1);
    chk("unc_done_lat", done_cyc[3] - acc_cyc[3], 4);
    chk("tmo_mem_n", mem_n[4], 1);
    chk("tmo_code", done_code[4], 2);
    chk("tmo_done_lat", done_cyc[4] - acc_cyc[4], 18);
    chk("tmo_dec_n", dec_n[4], 0);
    chk("edge_err", done_err[5], 0);
    chk("edge_corr", done_corr[5], 4);
    chk("edge_done_lat", done_cyc[5] - acc_cyc[5], 22);
    chk("fixtmo_code", done_code[6], 2);
    chk("fixtmo_corr", done_corr[6], 4);
    chk("fixtmo_dec_n", dec_n[6], 0);
    chk("fixtmo_done_lat", done_cyc[6] - acc_cyc[6], 20);

    // Reset while the fixer is busy with D0.
    mi = idle_in(); mi.rd_req = 1'b1; mi.rd_addr = 8'h11;
    apply(mi);                                   // IDLE, accepted
    @(negedge clk); apply(idle_in());            // ISSUE
    chk("rst_issue", int'(bus.mem_rd_en), 1);
    @(negedge clk);                              // WAIT_CHK
    mi = idle_in(); mi.chk_valid = 1'b1; mi.s0 = 4'd3; mi.s1 = 4'd0;
    apply(mi);
    @(negedge clk); apply(idle_in());            // FIX0_REQ
    chk("rst_fix_start", int'(bus.fix_start), 1);
    @(negedge clk);                              // FIX0_WAIT
    chk("rst_in_wait", int'(bus.fix_start), 0);
    reset = 1'b1;
    #1;
    chk("rst_rd_ready", int'(bus.rd_ready), 1);
    chk("rst_outputs", int'({bus.mem_rd_en, bus.fix_start, bus.fix_sel, bus.dec_en,
                             bus.dec_idx, bus.dec_sel_fix, bus.rd_done, bus.rd_err,
                             bus.err_code}), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_corr_cnt", int'(bus.corr_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mi = idle_in();
      if (c == 1) mi.fix_done = 1'b1;            // stale fixer answer
      apply(mi);
      @(negedge clk);
      chk("post_rst_no_done", int'(bus.rd_done), 0);
      chk("post_rst_ready", int'(bus.rd_ready), 1);
    end
    chk("post_rst_corr", int'(bus.corr_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_read_ctrl.md
Name: hamming_read_ctrl

Overview:
Read-path sequencer for the Hamming ECC RAID array. It accepts one read request at a time, issues the drive read for both data blocks (D0, D1), and waits for the checker syndromes. It then sends each corrupted codeword through the fixer in turn and drives the decoder one block per beat, selecting the raw or corrected source. It reports completion or error and keeps a saturating count of corrected codewords.

Parameters:
ADDR_W, 8, width of the block address.
TIMEOUT, 15, maximum cycles spent waiting in WAIT_CHK or in either FIX wait state before the read aborts with an error.
CNT_W, 16, width of the corrected-codeword counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rd_req  in  1  read request; accepted only when rd_ready=1
rd_addr  in  ADDR_W  read address; sampled when the request is accepted
rd_ready  out  1  high only in IDLE
mem_rd_en  out  1  one-cycle drive read strobe
mem_addr  out  ADDR_W  latched address; held from accept until return to IDLE
chk_valid  in  1  checker results valid
chk_synd_d0  in  4  D0 syndrome: 0=clean, 1..12=bit position, 13..15=uncorrectable
chk_synd_d1  in  4  D1 syndrome, same encoding as D0
fix_start  out  1  one-cycle fixer start pulse
fix_sel  out  1  codeword sent to the fixer: 0=D0, 1=D1
fix_done  in  1  fixer finished
dec_en  out  1  decoder load strobe, one cycle per block
dec_idx  out  1  block being decoded: 0=D0, 1=D1
dec_sel_fix  out  1  decoder source select: 1=corrected data, 0=raw encoded data
rd_done  out  1  one-cycle completion pulse
rd_err  out  1  qualifies rd_done; 1=read failed
err_code  out  2  00=none, 01=uncorrectable, 10=timeout; valid with rd_done
corr_cnt  out  CNT_W  saturating count of corrected codewords

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0 except rd_ready=1; corr_cnt=0; latched syndromes, address and timer cleared. Reset mid-transaction aborts the read with no rd_done.
- States: IDLE, ISSUE, WAIT_CHK, FIX0_REQ, FIX0_WAIT, FIX1_REQ, FIX1_WAIT, DEC0, DEC1, DONE.
- All outputs are Moore decodes of the registered state and registered flags.
- IDLE: when rd_req=1, latch rd_addr and go to ISSUE. While not in IDLE, rd_req is ignored.
- ISSUE: mem_rd_en=1 for exactly one cycle, then go to WAIT_CHK. Clear the timer.
- WAIT_CHK: on chk_valid, latch both syndromes, then branch:
  - either syndrome ≥13 → DONE with err_code=01;
  - else synd_d0≠0 → FIX0_REQ;
  - else synd_d1≠0 → FIX1_REQ;
  - else → DEC0.
  chk_valid in any other state is ignored.
- FIXn_REQ: fix_start=1 and fix_sel=n for one cycle, then go to FIXn_WAIT. Clear the timer. fix_sel holds n through FIXn_WAIT.
- FIXn_WAIT: on fix_done, set the fixed_n flag, increment corr_cnt (saturating at all-ones), then branch:
  - from FIX0_WAIT → FIX1_REQ if synd_d1≠0, else DEC0;
  - from FIX1_WAIT → DEC0.
- Timeout: the timer increments each cycle in WAIT_CHK and FIXn_WAIT. When the timer equals TIMEOUT and no chk_valid/fix_done arrives that cycle → DONE with err_code=10. If the event and the timeout coincide, the event wins.
- DEC0: dec_en=1, dec_idx=0, dec_sel_fix=fixed_0. DEC1: dec_en=1, dec_idx=1, dec_sel_fix=fixed_1. No decode beats are issued on an error path.
- DONE: rd_done=1 and rd_err=(err_code≠00) for one cycle, then go to IDLE. Clear the fixed flags and syndromes on entry to IDLE.
- Clean-read latency: rd_req accepted at cycle 0; mem_rd_en at cycle 1; chk_valid at cycle k → DEC0 at k+1, DEC1 at k+2, rd_done at k+3, rd_ready=1 at k+4.
- Each fix adds (fixer latency + 1) cycles.
- Back-to-back: a new request is accepted the first cycle rd_ready=1 after DONE.

Test Plan:
- Clean read: rd_addr=0x3C, chk_valid at cycle 4 with synd 0/0 → mem_rd_en at cycle 1 with mem_addr=0x3C; dec_en at cycles 5,6 with dec_sel_fix=0; rd_done at 7 with rd_err=0; corr_cnt=0.
- D1-only error: synd_d0=0, synd_d1=5, fix_done 3 cycles after fix_start → one fix_start with fix_sel=1; DEC0 with dec_sel_fix=0; DEC1 with dec_sel_fix=1; corr_cnt=1; rd_err=0.
- Both blocks corrupted: synd 3/9 → FIX0 then FIX1 in order; both decode beats use corrected data; corr_cnt increases by 2.
- Uncorrectable: synd_d0=14 → no fix_start, no dec_en; rd_done with rd_err=1, err_code=01.
- Timeout: chk_valid never asserted, TIMEOUT=15 → rd_done with err_code=10 after 16 WAIT_CHK cycles. Repeat with fix_done arriving exactly on the timeout cycle → fix is accepted and the read completes without error.
- Reset mid-FIX0_WAIT and rd_req while busy: reset → IDLE immediately, all outputs 0, corr_cnt=0, rd_ready=1, no rd_done. rd_req pulsed during WAIT_CHK → ignored, no second mem_rd_en.
